// File: rtl/serial_tx_queue.sv
// serial_tx_queue: FIFO feeder for the 32-bit serial transmitter.
// Buffers result words and hands them out one at a time, pacing each
// load_data pulse on the previous tran_done plus a configurable idle gap.
//
// Ports:
//   sclk, rst_n       clock (posedge) and asynchronous active-low reset
//   wr_en, wr_data    push a 32-bit word into the queue
//   clr_err           clears the overflow / err_timeout sticky flags
//   tran_done         one-cycle done pulse from the transmitter
//   load_data         one-cycle start pulse for the transmitter
//   data_out          word being transmitted, held until the next load
//   full, empty       queue status
//   level             queued words, excluding the word in flight
//   busy              a word is being loaded or is in flight
//   overflow          sticky: write attempted while full
//   err_timeout       sticky: transmitter did not answer in time
//
// Optional feature: define SERIAL_TXQ_TIMEOUT_EN to abort a transfer that
// gets no tran_done within TIMEOUT cycles of its load pulse.

module serial_tx_queue #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [31:0]       wr_data,
    input  logic              clr_err,
    input  logic              tran_done,
    output logic              load_data,
    output logic [31:0]       data_out,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              busy,
    output logic              overflow,
    output logic              err_timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      GAP_V    = 4'(GAP);

    if (DEPTH != (1 << ADDR_W) || DEPTH < 2 || GAP < 0 || GAP > 15
        || TIMEOUT < 1) begin : g_cfg_check
        $error("serial_tx_queue: illegal parameter combination");
    end

    logic [1:0]        state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [3:0]        gap_cnt;
    logic [31:0]       mem [DEPTH];
    logic              push;
    logic              pop;
    logic              timeout_hit;

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);
    assign busy  = (state != S_IDLE);

    // full/empty are decoded from the registered level, so a write on
    // the pop edge of a full queue is still refused.
    assign push = wr_en && !full;
    assign pop  = (state == S_IDLE) && !empty && (gap_cnt == 4'd0);

    always_ff @(posedge sclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clr_err) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            load_data <= 1'b0;
            data_out  <= '0;
            gap_cnt   <= '0;
        end else begin
            load_data <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end else if (!empty) begin
                        state     <= S_LOAD;
                        load_data <= 1'b1;
                        data_out  <= mem[rd_ptr];
                    end
                end
                S_LOAD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A timed-out word is dropped, not retried.
                    if (tran_done || timeout_hit) begin
                        gap_cnt <= GAP_V;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_TXQ_TIMEOUT_EN
    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts cycles since the load pulse; the LOAD cycle counts too.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (pop) begin
            wait_cnt <= '0;
        end else if (busy) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A done pulse on the final cycle wins over the timeout.
    assign timeout_hit = (state == S_WAIT) && !tran_done
                         && (wait_cnt == TO_LAST);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
        end else if (clr_err) begin
            err_timeout <= 1'b0;
        end else if (timeout_hit) begin
            err_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
